// File: rtl/fifo_pkt_reader_if.sv
// Payload byte stream leaving the packet reader: valid/ready beats with an end-of-packet flag.
interface fifo_pkt_reader_if;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/fifo_pkt_reader.sv
// Pops a length-prefixed byte stream from a synchronous FIFO and presents the payload as
// valid/ready beats through a 4-entry output buffer, counting completed packets.
//
// state  | meaning
// ST_HDR | next byte returned by the FIFO is a length byte
// ST_PAY | next byte returned by the FIFO is payload; `remaining` bytes still to come
module fifo_pkt_reader #(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                fifo_empty,
    input  logic [7:0]          fifo_dout,
    output logic                fifo_rd,
    fifo_pkt_reader_if.master   m,
    output logic [CNT_W-1:0]    pkt_cnt,
    output logic                pkt_done,
    output logic                zero_len
);
    localparam logic [0:0] ST_HDR = 1'b0;
    localparam logic [0:0] ST_PAY = 1'b1;

    logic [0:0] state;
    logic [7:0] remaining;
    logic       rd_q;
    logic [7:0] buf_data [4];
    logic       buf_last [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] occ;
    logic [3:0] credit;
    logic       push;
    logic       pop;
    logic       is_last;

    // The byte in flight counts against the buffer so it always has a slot to land in.
    assign credit  = {1'b0, occ} + {3'b000, rd_q};
    assign fifo_rd = rst && en && !fifo_empty && (credit < 4'd4);

    assign push    = rd_q && (state == ST_PAY);
    assign is_last = (remaining == 8'd1);
    assign pop     = m.m_valid && m.m_ready;

    assign m.m_valid = (occ != 3'd0);
    assign m.m_data  = m.m_valid ? buf_data[rd_ptr] : 8'h00;
    assign m.m_last  = m.m_valid && buf_last[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_HDR;
            remaining <= 8'd0;
            rd_q      <= 1'b0;
            pkt_cnt   <= '0;
            pkt_done  <= 1'b0;
            zero_len  <= 1'b0;
        end else begin
            rd_q     <= fifo_rd;
            pkt_done <= 1'b0;
            zero_len <= 1'b0;
            if (rd_q) begin
                if (state == ST_HDR) begin
                    if (fifo_dout == 8'h00) begin
                        zero_len <= 1'b1;
                    end else begin
                        remaining <= fifo_dout;
                        state     <= ST_PAY;
                    end
                end else begin
                    remaining <= remaining - 8'd1;
                    if (is_last) begin
                        state    <= ST_HDR;
                        pkt_done <= 1'b1;
                        pkt_cnt  <= pkt_cnt + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            occ    <= 3'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   occ <= occ + 3'd1;
                2'b01:   occ <= occ - 3'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            buf_data[wr_ptr] <= fifo_dout;
            buf_last[wr_ptr] <= is_last;
        end
    end
endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Bench for fifo_pkt_reader: a queue-backed FIFO model feeds the DUT and a packet-level
// scoreboard predicts every payload beat, pulse count and the packet counter.
module tb_fifo_pkt_reader;
    logic       clk;
    logic       rst;
    logic       en;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       fifo_rd;
    logic [3:0] pkt_cnt;
    logic       pkt_done;
    logic       zero_len;

    fifo_pkt_reader_if bus ();

    fifo_pkt_reader #(.CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd    (fifo_rd),
        .m          (bus),
        .pkt_cnt    (pkt_cnt),
        .pkt_done   (pkt_done),
        .zero_len   (zero_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] q [$];
    logic [8:0] exp_q [$];
    int mdl_rem = 0;
    int mdl_cnt = 0;
    int mdl_done = 0;
    int mdl_zero = 0;

    int seen_done = 0;
    int seen_zero = 0;
    int beat_cnt = 0;
    logic rd_now = 1'b0;
    logic prev_stall = 1'b0;
    logic [9:0] prev_beat = '0;
    logic s_rd, s_valid, s_last, s_ready, s_done, s_zero;
    logic [7:0] s_data;
    logic [3:0] s_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Packet-format reference: a length byte opens a packet, the following N bytes are payload.
    task automatic push_byte(input logic [7:0] b);
        q.push_back(b);
        if (mdl_rem == 0) begin
            if (b == 8'h00) mdl_zero++;
            else mdl_rem = int'(b);
        end else begin
            exp_q.push_back({(mdl_rem == 1), b});
            mdl_rem--;
            if (mdl_rem == 0) begin
                mdl_done++;
                mdl_cnt++;
            end
        end
    endtask

    task automatic sample();
        s_rd = fifo_rd; s_valid = bus.m_valid; s_last = bus.m_last; s_data = bus.m_data;
        s_ready = bus.m_ready; s_done = pkt_done; s_zero = zero_len; s_cnt = pkt_cnt;
        if (fifo_empty) chk("rd_while_empty", {31'd0, s_rd}, 0);
        if (!rst) chk("rd_in_reset", {31'd0, s_rd}, 0);
        if (prev_stall && rst) chk("stall_hold", {22'd0, s_valid, s_last, s_data}, {22'd0, prev_beat});
        prev_stall = s_valid && !s_ready && rst;
        prev_beat = {s_valid, s_last, s_data};
        if (s_valid && s_ready) begin
            beat_cnt++;
            if (exp_q.size() == 0) chk("extra_beat", {23'd0, s_last, s_data}, 32'h1ff);
            else chk("beat", {23'd0, s_last, s_data}, {23'd0, exp_q.pop_front()});
        end
        if (s_done) seen_done++;
        if (s_zero) seen_zero++;
        rd_now = s_rd;
    endtask

    // One clock: observe at the falling edge, then model the FIFO read port after the rising edge.
    task automatic cycle();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        if (rd_now) begin
            if (q.size() == 0) chk("fifo_underflow", 1, 0);
            else fifo_dout = q.pop_front();
        end
        fifo_empty = (q.size() == 0);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        bus.m_ready = 1'b1;
        en = 1'b1;
        while (!(q.size() == 0 && exp_q.size() == 0 && !s_valid && !s_rd) && n < budget) begin
            cycle();
            n++;
        end
        if (n >= budget) chk("drain_timeout", 1, 0);
        repeat (3) cycle();
    endtask

    initial begin
        int n, k, lasts, dn, rds, d0, z0, b0;
        logic [7:0] src [$];
        rst = 1'b0; en = 1'b0; fifo_empty = 1'b1; fifo_dout = 8'h00; bus.m_ready = 1'b0;
        repeat (3) cycle();
        chk("rst_valid", {31'd0, s_valid}, 0);
        chk("rst_data", {24'd0, s_data}, 0);
        chk("rst_cnt", {28'd0, s_cnt}, 0);
        chk("rst_pulses", {30'd0, s_done, s_zero}, 0);
        rst = 1'b1; en = 1'b1; bus.m_ready = 1'b1;
        cycle();

        // Back-to-back 02 11 22 01 33 x16: one read per byte, counter wraps at packet 16.
        for (int r = 0; r < 16; r++) begin
            push_byte(8'h02); push_byte(8'h11); push_byte(8'h22); push_byte(8'h01); push_byte(8'h33);
        end
        n = 0;
        do begin cycle(); n++; end while (!s_rd && n < 10);
        chk("b2b_start", {31'd0, s_rd}, 1);
        n = 0; lasts = 0; dn = 0;
        while (lasts < 32 && n < 300) begin
            cycle(); n++;
            if (s_valid && s_ready && s_last) lasts++;
            if (s_done) begin
                dn++;
                if (dn == 15) chk("cnt_at_15", {28'd0, s_cnt}, 15);
                if (dn == 16) chk("cnt_wrap", {28'd0, s_cnt}, 0);
            end
        end
        chk("b2b_cycles", n, 81);
        drain(50);
        chk("b2b_cnt", {28'd0, pkt_cnt}, mdl_cnt % 16);

        // Single packet after idle: first payload visible three cycles after the header read.
        d0 = seen_done;
        push_byte(8'h03); push_byte(8'hA1); push_byte(8'hA2); push_byte(8'hA3);
        n = 0;
        do begin cycle(); n++; end while (!s_rd && n < 10);
        k = 0;
        do begin cycle(); k++; end while (!s_valid && k < 10);
        chk("first_latency", k, 3);
        chk("first_data", {24'd0, s_data}, 32'hA1);
        drain(50);
        chk("single_done", seen_done - d0, 1);
        chk("single_cnt", {28'd0, pkt_cnt}, mdl_cnt % 16);

        // Backpressure: 255-byte packet, consumer stalled for 10 cycles.
        bus.m_ready = 1'b0;
        push_byte(8'hFF);
        for (int i = 0; i < 255; i++) push_byte(8'($urandom));
        rds = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (s_rd) rds++;
        end
        chk("bp_reads", rds, 5);
        chk("bp_valid", {31'd0, s_valid}, 1);
        d0 = seen_done;
        drain(600);
        chk("bp_done", seen_done - d0, 1);

        // Zero-length header followed by a 2-byte packet.
        z0 = seen_zero; d0 = seen_done;
        push_byte(8'h00); push_byte(8'h02); push_byte(8'h55); push_byte(8'h66);
        drain(50);
        chk("zero_pulses", seen_zero - z0, 1);
        chk("zero_done", seen_done - d0, 1);
        chk("zero_cnt", {28'd0, pkt_cnt}, mdl_cnt % 16);

        // Starvation after two of four payload bytes.
        d0 = seen_done; b0 = beat_cnt;
        push_byte(8'h04); push_byte(8'hB1); push_byte(8'hB2);
        repeat (10) cycle();
        chk("starve_beats", beat_cnt - b0, 2);
        chk("starve_idle", {31'd0, s_valid}, 0);
        push_byte(8'hB3); push_byte(8'hB4);
        drain(50);
        chk("starve_done", seen_done - d0, 1);

        // Enable dropped for 5 cycles mid-packet.
        d0 = seen_done;
        push_byte(8'h06);
        for (int i = 0; i < 6; i++) push_byte(8'hC0 + 8'(i));
        repeat (3) cycle();
        en = 1'b0;
        rds = 0;
        repeat (5) begin
            cycle();
            if (s_rd) rds++;
        end
        chk("en_off_reads", rds, 0);
        en = 1'b1;
        drain(50);
        chk("en_done", seen_done - d0, 1);

        // Randomized packets with random credit, enable and FIFO arrival gaps.
        d0 = seen_done; z0 = seen_zero;
        for (int p = 0; p < 30; p++) begin
            n = $urandom_range(0, 20);
            src.push_back(8'(n));
            for (int i = 0; i < n; i++) src.push_back(8'($urandom));
        end
        n = 0;
        while (src.size() != 0 && n < 5000) begin
            bus.m_ready = ($urandom_range(0, 3) != 0);
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 1) == 1) begin
                k = $urandom_range(1, 3);
                for (int i = 0; i < k && src.size() != 0; i++) push_byte(src.pop_front());
            end
            cycle(); n++;
        end
        drain(500);
        chk("rand_done", seen_done - d0, mdl_done - (d0));
        chk("rand_zero", seen_zero - z0, mdl_zero - z0);
        chk("rand_cnt", {28'd0, pkt_cnt}, mdl_cnt % 16);

        // Reset mid-payload with bytes buffered; next byte must be parsed as a header.
        bus.m_ready = 1'b0;
        push_byte(8'h05); push_byte(8'hD1); push_byte(8'hD2); push_byte(8'hD3);
        repeat (8) cycle();
        chk("pre_rst_valid", {31'd0, s_valid}, 1);
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        q.delete(); exp_q.delete(); mdl_rem = 0; mdl_cnt = 0; fifo_empty = 1'b1;
        cycle();
        chk("post_rst_valid", {31'd0, s_valid}, 0);
        chk("post_rst_cnt", {28'd0, s_cnt}, 0);
        d0 = seen_done;
        push_byte(8'h02); push_byte(8'hE1); push_byte(8'hE2);
        drain(50);
        chk("post_rst_done", seen_done - d0, 1);
        chk("post_rst_cnt1", {28'd0, pkt_cnt}, 1);
        chk("total_done", seen_done, mdl_done);
        chk("total_zero", seen_zero, mdl_zero);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_pkt_reader.md
# fifo_pkt_reader

Read-side controller for the 8-bit synchronous `fifo`. It pops bytes whenever the FIFO is non-empty and downstream credit exists. It parses a length-prefixed packet format: one length byte N, then N payload bytes. Payload is presented on a valid/ready byte stream with end-of-packet marking, and completed packets are counted. The block sits between the `fifo` read port (`rd`, `dout`, `empty`) and any byte consumer.

## Interface
- `CNT_W`, 16: width of the completed-packet counter.
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: synchronous, active-low reset.
- `en` input 1: when low, no new FIFO reads are issued. An in-flight byte still completes and the buffer still drains.
- `fifo_empty` input 1: `empty` from the FIFO.
- `fifo_dout` input 8: `dout` from the FIFO. Valid the cycle after `fifo_rd`.
- `fifo_rd` output 1: FIFO read strobe (combinational).
- `m_data` output 8: payload byte.
- `m_valid` output 1: `m_data`/`m_last` valid.
- `m_last` output 1: marks the final payload byte of a packet.
- `m_ready` input 1: consumer accepts the beat when `m_valid && m_ready`.
- `pkt_cnt` output CNT_W: completed packets, wraps modulo 2^CNT_W.
- `pkt_done` output 1: one-cycle pulse when a packet's last byte enters the buffer.
- `zero_len` output 1: one-cycle pulse when a length byte of 0x00 is consumed.

## Operation
- FIFO read protocol:
  - A `fifo_rd` issued in cycle t returns its byte on `fifo_dout` in cycle t+1.
  - A registered flag `rd_q` marks cycle t+1.
- Read issue rule: `fifo_rd = rst && en && !fifo_empty && (occ + rd_q) < 4`.
  - `occ` is the output buffer occupancy (0..4).
  - No dependence on `m_ready`, so there is no combinational path from `m_ready` to `fifo_rd`.
- Parser FSM, advanced only on cycles with `rd_q = 1`:
  - HDR, byte = 0: pulse `zero_len`, stay in HDR, push nothing.
  - HDR, byte = N ≠ 0: `remaining <= N`, go to PAY, push nothing.
  - PAY: push {byte, last = (`remaining` == 1)} and decrement `remaining`.
    - If `remaining` was 1: go to HDR, pulse `pkt_done`, `pkt_cnt <= pkt_cnt + 1`.
- `remaining` is 8 bits, so payload length is 1..255.
- Output buffer:
  - 4-entry circular buffer of {data, last}, with 2-bit pointers and a 3-bit `occ`.
  - Push and pop in the same cycle leave `occ` unchanged.
  - `m_valid = (occ != 0)`; `m_data`/`m_last` come from the head entry.
  - While `m_valid && !m_ready`, `m_data`/`m_last` stay stable.
  - Overflow is impossible by the credit rule.
- FIFO empties mid-packet: the FSM holds PAY and `remaining`, and resumes when bytes arrive.
- `en` deasserted mid-packet: same as starvation; no state is lost.
- Reset (`rst` = 0, sampled at the edge):
  - FSM goes to HDR; `remaining`, `rd_q`, `occ`, pointers and `pkt_cnt` are cleared.
  - `m_valid`, `m_last`, `pkt_done` and `zero_len` are 0; `m_data` is 0x00.
  - Buffer contents and any in-flight byte are discarded.
  - `fifo_rd` is 0 throughout reset.

## Timing
- Latency from a payload `fifo_rd` (cycle t) to that byte on `m_data` with `m_valid` = 1: cycle t+2.
- First payload of a packet after an idle period: header read at t, `m_valid` at t+3.
- Throughput with `m_ready` = 1 and a non-empty FIFO: one payload beat per cycle. Each header costs exactly one bubble cycle.
- `pkt_done`/`pkt_cnt` update in the cycle after the last byte's `rd_q` cycle, simultaneously with that byte becoming visible.
- `zero_len` is asserted in the cycle after the zero byte's `rd_q` cycle.
- Backpressure: at most 4 bytes are accepted beyond the consumer. `fifo_rd` stops within 1 cycle of `occ + rd_q` reaching 4.

## Test plan
- Single packet, FIFO holds 03 A1 A2 A3, `m_ready` = 1:
  - Beats A1, A2, A3; `m_last` only on A3.
  - One `pkt_done` pulse; `pkt_cnt` = 1.
  - A1 appears 3 cycles after the header `fifo_rd`.
- Back-to-back packets 02 11 22 01 33 with `CNT_W` = 4, repeated 16 times:
  - Beats 11, 22, 33 per repetition; `m_last` on 22 and 33.
  - Exactly one bubble per header.
  - `pkt_cnt` wraps 15 → 0 at packet 16.
- Backpressure with a 255-byte packet queued and `m_ready` = 0 for 10 cycles:
  - `fifo_rd` stops after 4 outstanding bytes; `m_data` is held stable.
  - After release: all 255 bytes in order, no loss or duplication, `m_last` on byte 255.
- Zero length, FIFO holds 00 02 55 66:
  - One `zero_len` pulse; no beat for 00.
  - Beats 55, 66 with `m_last` on 66; `pkt_cnt` = 1.
- Starvation and `en`:
  - FIFO empties after 2 of 4 payload bytes: `fifo_rd` never asserts while `fifo_empty` = 1.
  - Later bytes complete the packet correctly.
  - `en` low for 5 cycles mid-packet: no reads during that window; the packet completes afterwards.
- Reset mid-payload, `rst` = 0 for 1 cycle:
  - Next cycle: `m_valid` = 0, `pkt_cnt` = 0, `fifo_rd` = 0 during reset.
  - The next byte read is parsed as a length header.
